// File: rtl/tmds_pkg.sv
// tmds_pkg: TMDS control-token constants and receiver state encoding shared by the tmds_rx slice.
package tmds_pkg;
  localparam logic [9:0] TMDS_CTRL_00 = 10'h354;
  localparam logic [9:0] TMDS_CTRL_01 = 10'h0AB;
  localparam logic [9:0] TMDS_CTRL_10 = 10'h154;
  localparam logic [9:0] TMDS_CTRL_11 = 10'h2AB;
  typedef enum logic {RX_SEARCH, RX_LOCKED} rx_state_e;
endpackage

// File: rtl/tmds_sym_decode.sv
// tmds_sym_decode: combinational 10b TMDS symbol to control token or 8b data byte.
module tmds_sym_decode
  import tmds_pkg::*;
(
  input  logic [9:0] q,
  output logic       is_ctrl,
  output logic [1:0] ctrl,
  output logic [7:0] data
);
  logic [7:0] d;
  assign d = q[9] ? ~q[7:0] : q[7:0];
  assign data = {q[8] ? d[7:1] ^ d[6:0] : ~(d[7:1] ^ d[6:0]), d[0]};
  assign is_ctrl = q == TMDS_CTRL_00 || q == TMDS_CTRL_01 || q == TMDS_CTRL_10 || q == TMDS_CTRL_11;
  assign ctrl = q == TMDS_CTRL_01 ? 2'b01 : q == TMDS_CTRL_10 ? 2'b10 : q == TMDS_CTRL_11 ? 2'b11 : 2'b00;
endmodule

// File: rtl/tmds_rx.sv
// tmds_rx: three-lane TMDS receiver - deserialise, align on ch0 control tokens, decode to RGB + sync.
// Define TMDS_RX_ERR_CNT_EN to build the lane-disagreement counter behind err_count.
module tmds_rx
  import tmds_pkg::*;
#(
  parameter int LOCK_COUNT    = 8,
  parameter int SEARCH_WINDOW = 64,
  parameter int LOSS_TIMEOUT  = 65536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_10x,
  input  logic        ch0,
  input  logic        ch1,
  input  logic        ch2,
  output logic [23:0] data_out,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic        locked,
  output logic [3:0]  bit_offset,
  output logic [15:0] err_count
);
  localparam int HW = $clog2(LOCK_COUNT + 1);
  localparam int WW = $clog2(SEARCH_WINDOW + 1);
  localparam int LW = $clog2(LOSS_TIMEOUT + 1);
  localparam logic [HW-1:0] HIT_LOCK = HW'(LOCK_COUNT);
  localparam logic [WW-1:0] WIN_END  = WW'(SEARCH_WINDOW);
  localparam logic [LW-1:0] LOSS_END = LW'(LOSS_TIMEOUT);
  logic [2:0][9:0] sr, cur, prev;
  logic [9:0] win [3];
  logic [2:0] is_ctrl;
  logic [1:0] ctrl [3];
  logic [7:0] dat [3];
  rx_state_e state, state_d;
  logic [HW-1:0] hit_cnt, hit_d;
  logic [WW-1:0] win_cnt, win_d;
  logic [LW-1:0] loss_cnt, loss_d;
  logic [3:0] off_d;
  logic [23:0] data_q;
  logic de_q, hs_q, vs_q;
  logic unused_ctrl;
  always_ff @(posedge clk_10x)
    sr <= {{ch2, sr[2][9:1]}, {ch1, sr[1][9:1]}, {ch0, sr[0][9:1]}};
  // Two words of history let any 10-bit window straddle a word boundary.
  always_ff @(posedge clk) begin
    cur <= sr;
    prev <= cur;
  end
  for (genvar g = 0; g < 3; g++) begin : g_lane
    logic [19:0] cat;
    assign cat = {cur[g], prev[g]};
    assign win[g] = cat[bit_offset +: 10];
    tmds_sym_decode u_dec (.q(win[g]), .is_ctrl(is_ctrl[g]), .ctrl(ctrl[g]), .data(dat[g]));
  end
  always_comb begin
    state_d = state;
    hit_d = '0;
    win_d = '0;
    loss_d = '0;
    off_d = bit_offset;
    if (state == RX_SEARCH) begin
      hit_d = is_ctrl[0] ? hit_cnt + 1'b1 : '0;
      win_d = win_cnt + 1'b1;
      if (hit_d == HIT_LOCK) begin
        state_d = RX_LOCKED;
        hit_d = '0;
        win_d = '0;
      end else if (win_d == WIN_END) begin
        off_d = bit_offset == 4'd9 ? 4'd0 : bit_offset + 4'd1;
        hit_d = '0;
        win_d = '0;
      end
    end else begin
      loss_d = is_ctrl[0] ? '0 : loss_cnt + 1'b1;
      if (loss_d == LOSS_END) begin
        state_d = RX_SEARCH;
        loss_d = '0;
      end
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= RX_SEARCH;
      bit_offset <= '0;
      hit_cnt <= '0;
      win_cnt <= '0;
      loss_cnt <= '0;
    end else begin
      state <= state_d;
      bit_offset <= off_d;
      hit_cnt <= hit_d;
      win_cnt <= win_d;
      loss_cnt <= loss_d;
    end
  // Control periods freeze the pixel; data periods freeze the sync bits.
  always_ff @(posedge clk)
    if (rst) begin
      data_q <= '0;
      de_q <= 1'b0;
      hs_q <= 1'b0;
      vs_q <= 1'b0;
    end else begin
      de_q <= !is_ctrl[0];
      if (is_ctrl[0]) {vs_q, hs_q} <= ctrl[0];
      else data_q <= {dat[2], dat[1], dat[0]};
    end
  assign locked = state == RX_LOCKED;
  assign data_out = locked ? data_q : '0;
  assign de = locked && de_q;
  assign hsync = locked && hs_q;
  assign vsync = locked && vs_q;
`ifdef TMDS_RX_ERR_CNT_EN
  logic [15:0] err_q;
  always_ff @(posedge clk)
    if (rst) err_q <= '0;
    else if (locked && (is_ctrl[1] != is_ctrl[0] || is_ctrl[2] != is_ctrl[0]) && err_q != 16'hFFFF)
      err_q <= err_q + 16'd1;
  assign err_count = err_q;
  assign unused_ctrl = ^{ctrl[1], ctrl[2]};
`else
  assign err_count = '0;
  assign unused_ctrl = ^{ctrl[1], ctrl[2], is_ctrl[2:1]};
`endif
endmodule
